// File: rtl/doce_rx_pkg.sv
// Shared constants, bit-field positions, beat payload and FSM state for the DoCE RX MAC filter.
package doce_rx_pkg;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned KEEP_W = 16;
  localparam int unsigned USER_W = 4;
  localparam int unsigned MAC_W  = 48;
  localparam int unsigned ETYPE_W = 16;

  // tuser bit indices on the router side
  localparam int unsigned TUSER_BCAST_BIT = 0;
  localparam int unsigned TUSER_UCAST_BIT = 1;
  localparam int unsigned TUSER_RSVD_BIT  = 2;
  localparam int unsigned TUSER_BAD_BIT   = 3;

  // Field positions inside the first beat of a frame
  localparam int unsigned SRC_MAC_LSB = 0;
  localparam int unsigned SRC_MAC_MSB = 47;
  localparam int unsigned DST_MAC_LSB = 48;
  localparam int unsigned DST_MAC_MSB = 95;
  localparam int unsigned ETYPE_LSB   = 96;
  localparam int unsigned ETYPE_MSB   = 111;

  localparam logic [MAC_W-1:0]   BCAST_MAC              = 48'hFFFF_FFFF_FFFF;
  localparam logic [ETYPE_W-1:0] DEFAULT_DOCE_ETHERTYPE = 16'h88B5;

  // One forwarded beat as stored in the skid buffer
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic [USER_W-1:0] user;
  } rx_beat_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FWD     = 2'd1,
    ST_DISCARD = 2'd2
  } rx_state_e;

endpackage

// File: rtl/rx_filter_skid_buf.sv
// Two-entry FIFO holding accepted beats between the filter and the router.
module rx_filter_skid_buf
  import doce_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  rx_beat_t   push_beat_i,
  input  logic       pop_i,
  output rx_beat_t   head_o,
  output logic [1:0] count_o
);

  rx_beat_t   mem_q [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push_ok_c;
  logic       pop_ok_c;

  // Qualify push/pop against occupancy and compute next pointers/count
  always_comb begin
    pop_ok_c  = pop_i & (count_q != 2'd0);
    push_ok_c = push_i & ((count_q != 2'd2) | pop_ok_c);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push_ok_c) wr_ptr_d = ~wr_ptr_q;
    if (pop_ok_c)  rd_ptr_d = ~rd_ptr_q;
    case ({push_ok_c, pop_ok_c})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and occupancy; reset flushes everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok_c) mem_q[wr_ptr_q] <= push_beat_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/rx_mac_filter.sv
// Receive-side MAC filter: judges each frame on its first beat and forwards
// accepted DoCE frames through a 2-entry skid buffer with tuser classification.
// Optional frame statistics counters: define RX_FILTER_STATS_EN.
module rx_mac_filter
  import doce_rx_pkg::*;
#(
  parameter logic [15:0] DOCE_ETHERTYPE = DEFAULT_DOCE_ETHERTYPE
) (
  input  logic                user_clk,
  input  logic                reset,
  input  logic [MAC_W-1:0]    local_mac_addr,
  input  logic                promisc_en,
  input  logic [DATA_W-1:0]   axi_str_tdata_from_mac,
  input  logic [KEEP_W-1:0]   axi_str_tkeep_from_mac,
  input  logic                axi_str_tvalid_from_mac,
  input  logic                axi_str_tlast_from_mac,
  input  logic                axi_str_tuser_from_mac,
  output logic                axi_str_tready_to_mac,
  output logic [DATA_W-1:0]   axi_str_tdata_to_router,
  output logic [KEEP_W-1:0]   axi_str_tkeep_to_router,
  output logic                axi_str_tvalid_to_router,
  output logic                axi_str_tlast_to_router,
  output logic [USER_W-1:0]   axi_str_tuser_to_router,
  input  logic                axi_str_tready_from_router
`ifdef RX_FILTER_STATS_EN
  ,
  output logic [31:0]         rx_pkt_accept_cnt,
  output logic [31:0]         rx_pkt_drop_cnt
`endif
);

  rx_state_e   state_q, state_d;
  logic [1:0]  flags_q, flags_d;     // {ucast, bcast} of the frame in flight
  logic [1:0]  cur_flags_c;
  logic        in_hs_c;
  logic        first_hs_c;
  logic        bcast_c;
  logic        ucast_c;
  logic        accept_c;
  logic        push_c;
  logic        pop_c;
  rx_beat_t    push_beat_c;
  rx_beat_t    head;
  logic [1:0]  count;

  logic [MAC_W-1:0]   dst_mac_c;
  logic [ETYPE_W-1:0] etype_c;

  assign dst_mac_c = axi_str_tdata_from_mac[DST_MAC_MSB:DST_MAC_LSB];
  assign etype_c   = axi_str_tdata_from_mac[ETYPE_MSB:ETYPE_LSB];

  // First-beat classification
  assign bcast_c  = (dst_mac_c == BCAST_MAC);
  assign ucast_c  = (dst_mac_c == local_mac_addr);
  assign accept_c = (bcast_c | ucast_c | promisc_en) & (etype_c == DOCE_ETHERTYPE);

  // Input ready: always open while discarding, else limited by buffer space
  assign axi_str_tready_to_mac = ~reset & ((state_q == ST_DISCARD) | (count != 2'd2));

  assign in_hs_c    = axi_str_tvalid_from_mac & axi_str_tready_to_mac;
  assign first_hs_c = in_hs_c & (state_q == ST_IDLE);

  // Classification bits: live on the first beat, latched for the rest of the frame
  assign cur_flags_c = (state_q == ST_IDLE) ? {ucast_c, bcast_c} : flags_q;

  // Beat written into the skid buffer
  always_comb begin
    push_beat_c                      = '0;
    push_beat_c.data                 = axi_str_tdata_from_mac;
    push_beat_c.keep                 = axi_str_tkeep_from_mac;
    push_beat_c.last                 = axi_str_tlast_from_mac;
    push_beat_c.user[TUSER_BCAST_BIT] = cur_flags_c[0];
    push_beat_c.user[TUSER_UCAST_BIT] = cur_flags_c[1];
    push_beat_c.user[TUSER_RSVD_BIT]  = 1'b0;
    push_beat_c.user[TUSER_BAD_BIT]   = axi_str_tlast_from_mac & axi_str_tuser_from_mac;
  end

  // Next-state and buffer write decision
  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    push_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_hs_c) begin
          flags_d = {ucast_c, bcast_c};
          if (accept_c) begin
            push_c = 1'b1;
            if (!axi_str_tlast_from_mac) state_d = ST_FWD;
          end else if (!axi_str_tlast_from_mac) begin
            state_d = ST_DISCARD;
          end
        end
      end
      ST_FWD: begin
        if (in_hs_c) begin
          push_c = 1'b1;
          if (axi_str_tlast_from_mac) state_d = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (in_hs_c && axi_str_tlast_from_mac) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and latched classification
  always_ff @(posedge user_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      flags_q <= 2'b00;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  assign pop_c = axi_str_tvalid_to_router & axi_str_tready_from_router;

  rx_filter_skid_buf u_skid (
    .clk         (user_clk),
    .rst         (reset),
    .push_i      (push_c),
    .push_beat_i (push_beat_c),
    .pop_i       (pop_c),
    .head_o      (head),
    .count_o     (count)
  );

  assign axi_str_tvalid_to_router = (count != 2'd0);
  assign axi_str_tdata_to_router  = head.data;
  assign axi_str_tkeep_to_router  = head.keep;
  assign axi_str_tlast_to_router  = head.last;
  assign axi_str_tuser_to_router  = head.user;

`ifdef RX_FILTER_STATS_EN
  logic [31:0] accept_cnt_q, accept_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;

  // Saturating per-frame counters, stepped on the first-beat handshake
  always_comb begin
    accept_cnt_d = accept_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    if (first_hs_c && accept_c && (accept_cnt_q != 32'hFFFF_FFFF))
      accept_cnt_d = accept_cnt_q + 32'd1;
    if (first_hs_c && !accept_c && (drop_cnt_q != 32'hFFFF_FFFF))
      drop_cnt_d = drop_cnt_q + 32'd1;
  end

  // Counter registers
  always_ff @(posedge user_clk or posedge reset) begin
    if (reset) begin
      accept_cnt_q <= 32'd0;
      drop_cnt_q   <= 32'd0;
    end else begin
      accept_cnt_q <= accept_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign rx_pkt_accept_cnt = accept_cnt_q;
  assign rx_pkt_drop_cnt   = drop_cnt_q;
`else
  logic unused_first_hs;
  assign unused_first_hs = first_hs_c;
`endif

endmodule

// File: doc/rx_mac_filter.md
# rx_mac_filter

Receive-side MAC filter for the DoCE datapath, placed between the Ethernet MAC receive AXI4-Stream and the DoCE router. It inspects the first beat of every frame, accepts unicast-to-local, broadcast (or all frames in promiscuous mode) DoCE-ethertype frames, and silently discards everything else. Accepted frames are forwarded through a 2-entry skid buffer with a per-packet 4-bit tuser classification.

## Interface
- DOCE_ETHERTYPE, 16'h88B5, ethertype accepted as DoCE.
- user_clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- local_mac_addr  in  48  station MAC; sampled on every first beat.
- promisc_en  in  1  1 = skip destination-MAC check; ethertype check still applies.
- axi_str_tdata_from_mac  in  128  frame data; first beat: dst MAC [95:48], src MAC [47:0], ethertype [111:96].
- axi_str_tkeep_from_mac  in  16  byte enables.
- axi_str_tvalid_from_mac  in  1  beat valid.
- axi_str_tlast_from_mac  in  1  last beat of frame.
- axi_str_tuser_from_mac  in  1  bad-frame flag, meaningful on the tlast beat only.
- axi_str_tready_to_mac  out  1  beat accepted.
- axi_str_tdata_to_router  out  128  forwarded data.
- axi_str_tkeep_to_router  out  16  forwarded byte enables.
- axi_str_tvalid_to_router  out  1  forwarded beat valid.
- axi_str_tlast_to_router  out  1  forwarded last beat.
- axi_str_tuser_to_router  out  4  [0] broadcast, [1] unicast match, [2] always 0, [3] bad frame (tlast beat only).
- axi_str_tready_from_router  in  1  downstream ready.
- rx_pkt_accept_cnt  out  32  accepted frames (RX_FILTER_STATS_EN only).
- rx_pkt_drop_cnt  out  32  discarded frames (RX_FILTER_STATS_EN only).

## Operation
- Handshake on the input = tvalid_from_mac & tready_to_mac. Output handshake = tvalid_to_router & tready_from_router.
- FSM states: IDLE (expecting first beat), FWD, DISCARD.
- First-beat decision (combinational on the IDLE handshake beat):
  - bcast = dst MAC == 48'hFFFF_FFFF_FFFF; ucast = dst MAC == local_mac_addr.
  - accept = (bcast | ucast | promisc_en) & (ethertype == DOCE_ETHERTYPE).
- Transitions:
  - IDLE, accept & !tlast: write the beat to the buffer, go to FWD.
  - IDLE, accept & tlast: write the beat, stay IDLE.
  - IDLE, !accept & !tlast: go to DISCARD.
  - IDLE, !accept & tlast: stay IDLE.
  - FWD: write every beat; on tlast go to IDLE.
  - DISCARD: discard every beat; on tlast go to IDLE.
- tuser[1:0] are latched on the first beat and replicated on every beat of that frame. tuser[3] = tuser_from_mac on the tlast beat, 0 on all other beats.
- tready_to_mac:
  - 1 in DISCARD.
  - In IDLE and FWD: buffer count != 2.
  - Forced to 0 while reset is asserted.
- Buffer: 2-entry FIFO; tvalid_to_router = count != 0; output data = head entry. A simultaneous push and pop when count is 2 is impossible because tready is low. A simultaneous push and pop at count 1 keeps count at 1.
- Frames are never truncated or reordered. A dropped frame produces no output beats.

## Timing
- Reset values: tvalid_to_router 0, tdata/tkeep/tlast/tuser_to_router 0, tready_to_mac 0, state IDLE, count 0, counters 0.
- First cycle after reset deasserts: tready_to_mac = 1.
- Latency: a beat accepted at edge N is visible on the router side after edge N, i.e. 1 cycle.
- Throughput: 1 beat/cycle sustained while tready_from_router = 1, including back-to-back frames with a tlast followed by a first beat in the next cycle.
- Backpressure: tready_from_router low for k cycles stalls the input after at most 2 buffered beats.
- Reset mid-frame: the buffer is flushed and the partial frame is lost. The next frame is judged on its first beat.

## Configuration
- RX_FILTER_STATS_EN defined:
  - rx_pkt_accept_cnt increments once per accepted frame, on the first-beat handshake.
  - rx_pkt_drop_cnt increments once per dropped frame, on the first-beat handshake.
  - Both counters saturate at 32'hFFFF_FFFF.
- RX_FILTER_STATS_EN undefined: both ports and the counters are absent. All other behaviour is identical.

## Structure
- Package doce_rx_pkg holds:
  - tuser bit indices;
  - MAC and ethertype bit-field positions;
  - BCAST_MAC;
  - default DOCE_ETHERTYPE;
  - the FSM state enum.
- Sub-module rx_filter_skid_buf: the 2-entry FIFO carrying data, keep, last and user, with push/pop/count.

## Test plan
- Unicast to local_mac_addr 48'h0A0B0C0D0E0F, ethertype 16'h88B5, 4 beats, router ready -> 4 output beats 1 cycle later, tuser = 4'b0010.
- Broadcast dst, 1-beat frame -> one output beat with tlast = 1, tuser = 4'b0001; accept count becomes 1.
- dst 48'h112233445566, promisc_en = 0, 3 beats -> no output; tready_to_mac stays 1 throughout; drop count becomes 1. Repeat with promisc_en = 1 -> frame forwarded with tuser = 4'b0000.
- Ethertype 16'h0800 to local MAC -> dropped.
- Router ready held low 5 cycles during a 6-beat frame -> exactly 2 beats buffered, tready_to_mac low, no data loss, order preserved.
- Reset pulsed on beat 2 of a 5-beat accepted frame -> all outputs 0 during reset; the next valid frame is forwarded intact. Bad-frame flag set on tlast -> tuser[3] = 1 on the last beat only.
